// File: rtl/iagc_dac_sample_formatter_if.sv
// Sample-in / DAC-word-out bundle for the IAGC DAC sample formatter.
// Latency: n/a (wiring only).
// Backpressure: o_sample_ready / i_data_ready form a valid-ready pair on each side.
//
// Signals keep the formatter's port names. The i_/o_ prefixes are seen from the
// formatter:
//   i_iagc_status  IAGC state, all-zero = IAGC in reset (unity gain bypass)
//   i_gain         unsigned gain, sampled with each accepted sample
//   i_sample       signed input sample, qualified by i_sample_valid / o_sample_ready
//   o_data         packed DAC word, qualified by o_data_valid / i_data_ready
//   o_saturated    one-cycle pulse when a clipped word enters the output register
//   o_sat_count    saturating count of clipped words
// modport slave is the formatter side. modport master is the source/sink side.
interface iagc_dac_sample_formatter_if #(
    parameter int ZMOD_DATA_SIZE   = 14,
    parameter int AXIS_DATA_SIZE   = 32,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int GAIN_SIZE        = 8,
    parameter int SAT_COUNT_SIZE   = 16
);
    logic [IAGC_STATUS_SIZE-1:0] i_iagc_status;
    logic [GAIN_SIZE-1:0]        i_gain;
    logic [ZMOD_DATA_SIZE-1:0]   i_sample;
    logic                        i_sample_valid;
    logic                        o_sample_ready;
    logic [AXIS_DATA_SIZE-1:0]   o_data;
    logic                        o_data_valid;
    logic                        i_data_ready;
    logic                        o_saturated;
    logic [SAT_COUNT_SIZE-1:0]   o_sat_count;

    modport slave (
        input  i_iagc_status,
        input  i_gain,
        input  i_sample,
        input  i_sample_valid,
        output o_sample_ready,
        output o_data,
        output o_data_valid,
        input  i_data_ready,
        output o_saturated,
        output o_sat_count
    );

    modport master (
        output i_iagc_status,
        output i_gain,
        output i_sample,
        output i_sample_valid,
        input  o_sample_ready,
        input  o_data,
        input  o_data_valid,
        output i_data_ready,
        input  o_saturated,
        input  o_sat_count
    );
endinterface

// File: rtl/iagc_dac_sample_formatter.sv
// Applies the IAGC gain to a signed sample stream and packs the rounded and saturated result into the DAC word.
// Latency: 2 cycles from input accept to o_data_valid. Throughput is 1 sample per cycle.
// Backpressure: the whole pipe stalls while the output holds an unaccepted word. o_sample_ready is the advance term.
//
// Ports:
//   i_dac_clock  sole clock (DAC domain)
//   i_reset      synchronous, active-high reset
//   bus          iagc_dac_sample_formatter_if.slave (sample in, DAC word out, saturation status)
//
// Optional build macro IAGC_DAC_OFFSET_BINARY_EN: when defined, the MSB of each packed sample
// is inverted, which gives offset-binary output. Saturation and counting do not change.
//
// Pipeline:
//   stage 1   registers the product of the sample and the selected gain
//   stage 2   rounds, saturates and packs the stage-1 product (combinational)
//   output    registers the packed word, the saturation pulse and the counter
module iagc_dac_sample_formatter #(
    parameter int ZMOD_DATA_SIZE   = 14,
    parameter int AXIS_DATA_SIZE   = 32,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int GAIN_SIZE        = 8,
    parameter int GAIN_FRAC        = 4,
    parameter int SAT_COUNT_SIZE   = 16
) (
    input  logic                        i_dac_clock,
    input  logic                        i_reset,
    iagc_dac_sample_formatter_if.slave  bus
);

    // Holds the full signed x unsigned product.
    localparam int PROD_W  = ZMOD_DATA_SIZE + GAIN_SIZE + 1;
    // Each channel sits 2 bits above the bottom of its 16-bit half.
    localparam int CH2_LSB = 2;
    localparam int CH1_LSB = (AXIS_DATA_SIZE / 2) + 2;

    localparam logic [GAIN_SIZE-1:0] GAIN_ONE =
        {{(GAIN_SIZE-1){1'b0}}, 1'b1} << GAIN_FRAC;
    localparam logic signed [PROD_W-1:0] ROUND_ADD =
        {{(PROD_W-1){1'b0}}, 1'b1} << (GAIN_FRAC - 1);
    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W-ZMOD_DATA_SIZE+1){1'b0}}, {(ZMOD_DATA_SIZE-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W-ZMOD_DATA_SIZE+1){1'b1}}, {(ZMOD_DATA_SIZE-1){1'b0}}};

    // ---------------------------------------------------------------- state
    logic                       s1_vld_q,   s1_vld_d;
    logic signed [PROD_W-1:0]   s1_prod_q,  s1_prod_d;
    logic                       out_vld_q,  out_vld_d;
    logic [AXIS_DATA_SIZE-1:0]  out_dat_q,  out_dat_d;
    logic                       sat_q,      sat_d;
    logic [SAT_COUNT_SIZE-1:0]  sat_cnt_q,  sat_cnt_d;

    // ---------------------------------------------------------------- comb
    logic                        advance;
    logic                        accept;
    logic [IAGC_STATUS_SIZE-1:0] iagc_status;
    logic [GAIN_SIZE-1:0]        gain_eff;
    logic signed [PROD_W-1:0]    samp_ext;
    logic signed [PROD_W-1:0]    gain_ext;
    logic signed [PROD_W-1:0]    prod;
    logic signed [PROD_W-1:0]    rnd_sum;
    logic signed [PROD_W-1:0]    rnd_shift;
    logic                        clip_hi;
    logic                        clip_lo;
    logic                        clip;
    logic [ZMOD_DATA_SIZE-1:0]   y_sat;
    logic [ZMOD_DATA_SIZE-1:0]   y_fmt;
    logic [AXIS_DATA_SIZE-1:0]   pack_word;

    // Stage 1 input side: handshake, gain select and multiply.
    always_comb begin
        advance     = !out_vld_q || bus.i_data_ready;
        accept      = bus.i_sample_valid && advance;
        iagc_status = bus.i_iagc_status;

        // While IAGC is held in reset, force unity gain so samples pass through unchanged.
        gain_eff = (iagc_status == '0) ? GAIN_ONE : bus.i_gain;

        // The operands are widened to the product width, so a signed multiply of the
        // same width is exact. Zero-extending the gain keeps it unsigned.
        samp_ext = {{(PROD_W-ZMOD_DATA_SIZE){bus.i_sample[ZMOD_DATA_SIZE-1]}}, bus.i_sample};
        gain_ext = {{(PROD_W-GAIN_SIZE){1'b0}}, gain_eff};
        prod     = samp_ext * gain_ext;
    end

    // Stage 2: round half toward +inf, then saturate to the DAC range and pack.
    always_comb begin
        // The largest product magnitude stays well inside PROD_W, so adding the
        // rounding constant cannot overflow.
        rnd_sum   = s1_prod_q + ROUND_ADD;
        rnd_shift = rnd_sum >>> GAIN_FRAC;

        clip_hi = rnd_shift > SAT_MAX;
        clip_lo = rnd_shift < SAT_MIN;
        clip    = clip_hi || clip_lo;

        if (clip_hi) begin
            y_sat = SAT_MAX[ZMOD_DATA_SIZE-1:0];
        end else if (clip_lo) begin
            y_sat = SAT_MIN[ZMOD_DATA_SIZE-1:0];
        end else begin
            y_sat = rnd_shift[ZMOD_DATA_SIZE-1:0];
        end

`ifdef IAGC_DAC_OFFSET_BINARY_EN
        y_fmt = {~y_sat[ZMOD_DATA_SIZE-1], y_sat[ZMOD_DATA_SIZE-2:0]};
`else
        y_fmt = y_sat;
`endif

        // Channel 1 and channel 2 carry the same sample. Unused low bits stay zero.
        pack_word = '0;
        pack_word[CH1_LSB +: ZMOD_DATA_SIZE] = y_fmt;
        pack_word[CH2_LSB +: ZMOD_DATA_SIZE] = y_fmt;
    end

    // Next state. Every stage moves together on advance, and bubbles move with it.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_prod_d = s1_prod_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        sat_d     = 1'b0;
        sat_cnt_d = sat_cnt_q;

        if (advance) begin
            s1_vld_d  = accept;
            // The gain is frozen into the product here. Later gain changes cannot
            // affect a sample that has already been accepted.
            if (accept) begin
                s1_prod_d = prod;
            end

            out_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                out_dat_d = pack_word;
            end

            // Report a clipped word once, as it enters the output register.
            if (s1_vld_q && clip) begin
                sat_d = 1'b1;
                if (sat_cnt_q != '1) begin
                    sat_cnt_d = sat_cnt_q + SAT_COUNT_SIZE'(1);
                end
            end
        end
    end

    always_ff @(posedge i_dac_clock) begin
        if (i_reset) begin
            s1_vld_q  <= 1'b0;
            s1_prod_q <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            sat_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_prod_q <= s1_prod_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            sat_q     <= sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.o_sample_ready = advance;
    assign bus.o_data         = out_dat_q;
    assign bus.o_data_valid   = out_vld_q;
    assign bus.o_saturated    = sat_q;
    assign bus.o_sat_count    = sat_cnt_q;

endmodule

// File: tb/tb_iagc_dac_sample_formatter.sv
`timescale 1ns/1ps
// Bench for iagc_dac_sample_formatter: directed vector table, back-pressure, random scoreboard, mid-stream reset.
// Latency: drives inputs at posedge+1 and samples outputs on the falling edge.
// Backpressure: applies stalls both as a fixed window and at random.
module tb_iagc_dac_sample_formatter;

    localparam int ZW = 14;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int GW = 8;
    localparam int GF = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iagc_dac_sample_formatter_if #(
        .ZMOD_DATA_SIZE(ZW), .AXIS_DATA_SIZE(AW), .IAGC_STATUS_SIZE(SW),
        .GAIN_SIZE(GW), .SAT_COUNT_SIZE(CW)
    ) bus ();

    iagc_dac_sample_formatter #(
        .ZMOD_DATA_SIZE(ZW), .AXIS_DATA_SIZE(AW), .IAGC_STATUS_SIZE(SW),
        .GAIN_SIZE(GW), .GAIN_FRAC(GF), .SAT_COUNT_SIZE(CW)
    ) dut (
        .i_dac_clock (clk),
        .i_reset     (rst),
        .bus         (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic. Returns {saturated, word}.
    function automatic logic [32:0] ref_out(input logic [3:0] st, input logic [7:0] g,
                                            input logic signed [13:0] s);
        int p;
        int r;
        int eff;
        logic sat;
        logic [13:0] y;
        eff = (st == 4'd0) ? 16 : int'(g);
        p   = int'(s) * eff;
        r   = (p + 8) >>> 4;
        sat = 1'b0;
        if (r > 8191) begin
            r = 8191;
            sat = 1'b1;
        end else if (r < -8192) begin
            r = -8192;
            sat = 1'b1;
        end
        y = r[13:0];
`ifdef IAGC_DAC_OFFSET_BINARY_EN
        y[13] = ~y[13];
`endif
        return {sat, y, 2'b00, y, 2'b00};
    endfunction

    typedef struct {
        logic [3:0]         st;
        logic [7:0]         g;
        logic signed [13:0] s;
        logic [31:0]        exp_dat;
        logic               exp_sat;
    } vec_t;

    vec_t tbl[6];
    int   exp_cnt;
    int   sat_model;

    initial begin
        tbl[0] = '{4'd1, 8'h10,  14'sd1000,  32'h0FA0_0FA0, 1'b0};
        tbl[1] = '{4'd1, 8'h20,  14'sd5000,  32'h7FFC_7FFC, 1'b1};
        tbl[2] = '{4'd1, 8'h20, -14'sd8192,  32'h8000_8000, 1'b1};
        tbl[3] = '{4'd1, 8'h18,  14'sd3,     32'h0014_0014, 1'b0};
        tbl[4] = '{4'd1, 8'h18, -14'sd3,     32'hFFF0_FFF0, 1'b0};
        tbl[5] = '{4'd0, 8'h40, -14'sd100,   32'hFE70_FE70, 1'b0};
`ifdef IAGC_DAC_OFFSET_BINARY_EN
        for (int i = 0; i < 6; i++) tbl[i].exp_dat = tbl[i].exp_dat ^ 32'h8000_8000;
`endif

        rst = 1'b1;
        bus.i_iagc_status  = 4'd1;
        bus.i_gain         = 8'h10;
        bus.i_sample       = '0;
        bus.i_sample_valid = 1'b0;
        bus.i_data_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // ---- reset values
        @(negedge clk);
        check("rst_valid", bus.o_data_valid, 0);
        check("rst_data",  bus.o_data, 0);
        check("rst_sat",   bus.o_saturated, 0);
        check("rst_cnt",   bus.o_sat_count, 0);
        check("rst_ready", bus.o_sample_ready, 1);

        // ---- vector table: single samples, latency and one-cycle valid
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.i_iagc_status  = tbl[i].st;
            bus.i_gain         = tbl[i].g;
            bus.i_sample       = tbl[i].s;
            bus.i_sample_valid = 1'b1;
            @(posedge clk); #1;
            bus.i_sample_valid = 1'b0;
            bus.i_gain         = 8'hFF;  // late gain change must not affect the accepted sample
            bus.i_iagc_status  = 4'd1;
            @(negedge clk);
            check("vec_lat1_valid", bus.o_data_valid, 0);
            @(negedge clk);
            if (tbl[i].exp_sat) exp_cnt++;
            check("vec_valid", bus.o_data_valid, 1);
            check("vec_data",  bus.o_data, tbl[i].exp_dat);
            check("vec_sat",   bus.o_saturated, tbl[i].exp_sat);
            check("vec_cnt",   bus.o_sat_count, exp_cnt);
            @(negedge clk);
            check("vec_valid_off", bus.o_data_valid, 0);
            check("vec_sat_off",   bus.o_saturated, 0);
        end

        // ---- back-pressure: samples 1..6 with ready low for cycles 2..8
        begin : bp
            int idx;
            logic [31:0] got[$];
            logic [31:0] hold;
            logic holding;
            logic saw_drop;
            logic [32:0] r;
            idx = 0; holding = 1'b0; saw_drop = 1'b0; hold = '0;
            for (int c = 0; c < 24; c++) begin
                @(posedge clk); #1;
                bus.i_iagc_status  = 4'd1;
                bus.i_gain         = 8'h10;
                bus.i_sample       = 14'(idx + 1);
                bus.i_sample_valid = (idx < 6);
                bus.i_data_ready   = !(c >= 2 && c <= 8);
                @(negedge clk);
                check("bp_ready_rule", bus.o_sample_ready,
                      !(bus.o_data_valid && !bus.i_data_ready));
                if (!bus.o_sample_ready) saw_drop = 1'b1;
                if (holding) begin
                    check("bp_hold_valid", bus.o_data_valid, 1);
                    check("bp_hold_data",  bus.o_data, hold);
                end
                holding = bus.o_data_valid && !bus.i_data_ready;
                hold    = bus.o_data;
                if (bus.o_data_valid && bus.i_data_ready) got.push_back(bus.o_data);
                if (bus.i_sample_valid && bus.o_sample_ready) idx++;
            end
            check("bp_ready_dropped", saw_drop, 1);
            check("bp_count", got.size(), 6);
            for (int k = 0; k < got.size(); k++) begin
                r = ref_out(4'd1, 8'h10, 14'(k + 1));
                check("bp_word", got[k], r[31:0]);
            end
        end

        // ---- random stream against the scoreboard
        begin : rnd
            logic [32:0] q[$];
            logic prev_vld;
            logic prev_hs;
            logic new_w;
            sat_model = 0;
            prev_vld = 1'b0; prev_hs = 1'b0;
            for (int c = 0; c < 420; c++) begin
                @(posedge clk); #1;
                if (c < 400) begin
                    bus.i_iagc_status  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                    bus.i_gain         = 8'($urandom);
                    bus.i_sample       = 14'($urandom);
                    bus.i_sample_valid = ($urandom_range(0, 3) != 0);
                    bus.i_data_ready   = ($urandom_range(0, 3) != 0);
                end else begin
                    bus.i_sample_valid = 1'b0;
                    bus.i_data_ready   = 1'b1;
                end
                @(negedge clk);
                new_w = bus.o_data_valid && (!prev_vld || prev_hs);
                if (bus.o_data_valid) begin
                    if (q.size() == 0) begin
                        check("rnd_spurious_valid", bus.o_data_valid, 0);
                    end else begin
                        check("rnd_data", bus.o_data, q[0][31:0]);
                        if (new_w) check("rnd_sat_pulse", bus.o_saturated, q[0][32]);
                    end
                end
                if (!new_w) check("rnd_sat_quiet", bus.o_saturated, 0);
                prev_vld = bus.o_data_valid;
                prev_hs  = bus.o_data_valid && bus.i_data_ready;
                if (bus.o_data_valid && bus.i_data_ready && q.size() != 0) void'(q.pop_front());
                if (bus.i_sample_valid && bus.o_sample_ready) begin
                    q.push_back(ref_out(bus.i_iagc_status, bus.i_gain, bus.i_sample));
                    if (q[q.size()-1][32]) sat_model++;
                end
            end
            check("rnd_drained", q.size(), 0);
            check("rnd_sat_count", bus.o_sat_count, exp_cnt + sat_model);
        end

        // ---- reset with two samples in flight (one in stage 1, one stalled in output)
        @(posedge clk); #1;
        bus.i_data_ready   = 1'b0;
        bus.i_iagc_status  = 4'd1;
        bus.i_gain         = 8'h20;
        bus.i_sample       = 14'sd5000;
        bus.i_sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_sample       = 14'sd6000;
        @(posedge clk); #1;
        bus.i_sample_valid = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", bus.o_data_valid, 1);
        check("mid_pre_cnt",   bus.o_sat_count, exp_cnt + sat_model + 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.i_data_ready = 1'b1;
        @(negedge clk);
        check("mid_valid", bus.o_data_valid, 0);
        check("mid_cnt",   bus.o_sat_count, 0);
        check("mid_ready", bus.o_sample_ready, 1);
        check("mid_data",  bus.o_data, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("mid_no_ghost", bus.o_data_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
